// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: instruction-memory request/response side plus the
// decode-facing FIFO head, redirect input and current fetch PC.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic [31:0] pc_out;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr, pc_out,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, pc_out,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, fetched words
// buffered with their PC in a small FIFO, redirects flush and squash in-flight data.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [63:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [63:0]   w_head;
    logic [31:0]   w_target;

    // Issue only when a FIFO slot is guaranteed for the response.
    assign w_req    = ~rst & (r_state == S_REQ) & (r_count < DEPTH_C) & ~bus.redirect;
    assign w_issue  = w_req & bus.imem_gnt;
    assign w_push   = (r_state == S_WAIT) & bus.imem_rvalid & ~bus.redirect;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid & bus.if_ready & ~bus.redirect;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_target = bus.redirect_pc & ~32'h3;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.if_valid  = w_valid;
    assign bus.if_pc     = w_valid ? w_head[63:32] : '0;
    assign bus.if_instr  = w_valid ? w_head[31:0]  : '0;
    assign bus.pc_out    = r_fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc <= w_target;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            // A request still in flight must be drained before issuing again.
            case (r_state)
                S_WAIT:  r_state <= bus.imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: r_state <= bus.imem_rvalid ? S_REQ : S_DRAIN;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_issue) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT:  if (bus.imem_rvalid) r_state <= S_REQ;
                S_DRAIN: if (bus.imem_rvalid) r_state <= S_REQ;
                default: r_state <= S_REQ;
            endcase
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_req_pc <= r_fetch_pc;
        if (w_push)  r_mem[r_wr_ptr] <= {r_req_pc, bus.imem_rdata};
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based fetch model.
module tb_fetch_ctrl;
    localparam logic [31:0] RPC = 32'h0000_1000;
    localparam int          DEP = 2;

    logic clk;
    logic rst;
    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RPC), .DEPTH(DEP)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // Model state: FIFO contents, next fetch PC, in-flight request bookkeeping.
    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_out;
    bit          m_squash;
    int          m_wait;
    bit          m_req;

    logic        t_gnt, t_rv, t_redir, t_rdy;
    logic [31:0] t_rd, t_rpc;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc     = RPC;
        m_out    = 1'b0;
        m_squash = 1'b0;
        m_wait   = 0;
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        t_gnt = g; t_rv = rv; t_rd = rd; t_redir = redir; t_rpc = rpc; t_rdy = rdy;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.if_ready    = rdy;
        #1;
        m_req = !m_out && (q.size() < DEP) && !redir;
        cmp("imem_req", {31'b0, bus.imem_req}, {31'b0, m_req});
        if (m_req) cmp("imem_addr", bus.imem_addr, m_pc);
        cmp("if_valid", {31'b0, bus.if_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        if (q.size() != 0) begin
            cmp("if_pc", bus.if_pc, q[0].pc);
            cmp("if_instr", bus.if_instr, q[0].instr);
        end
        cmp("pc_out", bus.pc_out, m_pc);
    endtask

    task automatic step();
        ent_t e;
        bit   pushv;
        @(posedge clk);
        pushv = 1'b0;
        if (m_out && !t_rv && m_wait > 0) m_wait--;
        if (t_redir) begin
            q.delete();
            m_pc = t_rpc & ~32'h3;
            if (m_out) begin
                if (t_rv) m_out = 1'b0;
                else      m_squash = 1'b1;
            end
        end else begin
            if (m_out && t_rv) begin
                if (!m_squash) begin
                    e.pc = m_pend; e.instr = t_rd; pushv = 1'b1;
                end
                m_out = 1'b0;
                m_squash = 1'b0;
            end
            if (q.size() != 0 && t_rdy) void'(q.pop_front());
            if (pushv) q.push_back(e);
            if (m_req && t_gnt) begin
                m_out    = 1'b1;
                m_squash = 1'b0;
                m_pend   = m_pc;
                m_pc     = m_pc + 32'd4;
                m_wait   = $urandom_range(0, 2);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus.redirect = 0; bus.redirect_pc = 0; bus.if_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        g, rv, redir, rdy;
        logic [31:0] rd, rpc;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        cmp("rst_req", {31'b0, bus.imem_req}, 32'd0);
        cmp("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        cmp("rst_pc_out", bus.pc_out, 32'h0000_1000);
        cmp("rst_if_pc", bus.if_pc, 32'd0);
        cmp("rst_if_instr", bus.if_instr, 32'd0);
        #5 rst = 1'b0;

        // First fetch and response
        drive(0, 0, 0, 0, 0, 0);
        cmp("t1_req", {31'b0, bus.imem_req}, 32'd1);
        cmp("t1_addr", bus.imem_addr, 32'h0000_1000);
        step();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 1, 32'h0050_0093, 0, 0, 0);
        cmp("t1_wait_req", {31'b0, bus.imem_req}, 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        cmp("t1_valid", {31'b0, bus.if_valid}, 32'd1);
        cmp("t1_if_pc", bus.if_pc, 32'h0000_1000);
        cmp("t1_if_instr", bus.if_instr, 32'h0050_0093);
        cmp("t1_next_addr", bus.imem_addr, 32'h0000_1004);
        step();

        // Fill the FIFO, then a single pop reopens issue
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 1, 32'h00A0_0113, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0);
        cmp("t2_full_req", {31'b0, bus.imem_req}, 32'd0);
        cmp("t2_head_pc", bus.if_pc, 32'h0000_1000);
        step();
        drive(0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0);
        cmp("t2_req", {31'b0, bus.imem_req}, 32'd1);
        cmp("t2_addr", bus.imem_addr, 32'h0000_1008);
        cmp("t2_head_pc", bus.if_pc, 32'h0000_1004);
        cmp("t2_head_instr", bus.if_instr, 32'h00A0_0113);
        step();

        // Redirect while waiting: in-flight response must be squashed
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 1, 32'h0000_2002, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        cmp("t3_valid", {31'b0, bus.if_valid}, 32'd0);
        cmp("t3_pc_out", bus.pc_out, 32'h0000_2000);
        cmp("t3_drain_req", {31'b0, bus.imem_req}, 32'd0);
        step();
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        cmp("t3_valid_after", {31'b0, bus.if_valid}, 32'd0);
        cmp("t3_req", {31'b0, bus.imem_req}, 32'd1);
        cmp("t3_addr", bus.imem_addr, 32'h0000_2000);
        step();

        // Redirect coincident with the response
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 1, 32'h1111_1111, 1, 32'h0000_3007, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        cmp("t4_valid", {31'b0, bus.if_valid}, 32'd0);
        cmp("t4_req", {31'b0, bus.imem_req}, 32'd1);
        cmp("t4_addr", bus.imem_addr, 32'h0000_3004);
        step();

        // PC wrap at the top of the address space
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0); step();
        drive(1, 0, 0, 0, 0, 0);
        cmp("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        drive(0, 1, 32'h1234_5678, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        cmp("t5_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        cmp("t5_addr_wrap", bus.imem_addr, 32'h0000_0000);
        step();

        // Asynchronous reset while a request is outstanding
        drive(1, 0, 0, 0, 0, 0); step();
        #3;
        idle_inputs();
        rst = 1'b1;
        #1;
        cmp("t6_req", {31'b0, bus.imem_req}, 32'd0);
        cmp("t6_valid", {31'b0, bus.if_valid}, 32'd0);
        cmp("t6_pc_out", bus.pc_out, 32'h0000_1000);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        drive(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
        cmp("t6_resume_addr", bus.imem_addr, 32'h0000_1000);
        step();
        drive(0, 0, 0, 0, 0, 0);
        cmp("t6_no_push", {31'b0, bus.if_valid}, 32'd0);
        cmp("t6_req_again", {31'b0, bus.imem_req}, 32'd1);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            g     = ($urandom_range(0, 9) < 7);
            rdy   = ($urandom_range(0, 9) < 6);
            redir = ($urandom_range(0, 19) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            rd    = $urandom;
            if (m_out) rv = (m_wait == 0);
            else       rv = ($urandom_range(0, 19) == 0);
            drive(g, rv, rd, redir, rpc, rdy);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
